// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
//   - lsu_state_e : sequencer states
//   - F3_*        : RV64 load/store funct3 encodings
//   - SZ_*        : access size encodings (funct3[1:0])
//   - lsu_req_t   : latched request
//   - size_bytes(), is_misaligned() helpers
package lsu_pkg;

  localparam int LSU_XLEN        = 64;
  localparam int LSU_OFFSET_BITS = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_RD,
    S_STORE_WR,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP,
    S_FAULT
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef struct packed {
    logic                is_store;
    logic [2:0]          funct3;
    logic [LSU_XLEN-1:0] addr;
    logic [LSU_XLEN-1:0] wdata;
  } lsu_req_t;

  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    return 4'd1 << sz;
  endfunction

  // Natural alignment: the offset must be a multiple of the access size.
  function automatic logic is_misaligned(input logic [1:0] sz,
                                         input logic [LSU_OFFSET_BITS-1:0] off);
    case (sz)
      SZ_H:    return off[0];
      SZ_W:    return |off[1:0];
      SZ_D:    return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic for the load/store unit.
//   word       : doubleword read from memory
//   off        : byte offset within the doubleword
//   funct3     : size in [1:0], unsigned-load flag in [2]
//   wdata      : right-justified store data
//   load_data  : extracted and sign/zero-extended load result
//   store_word : word with the addressed bytes replaced by wdata
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int OFFSET_BITS = 3
) (
  input  logic [XLEN-1:0]        word,
  input  logic [OFFSET_BITS-1:0] off,
  input  logic [2:0]             funct3,
  input  logic [XLEN-1:0]        wdata,
  output logic [XLEN-1:0]        load_data,
  output logic [XLEN-1:0]        store_word
);

  logic [OFFSET_BITS+2:0] bit_off;
  logic [XLEN-1:0]        shifted;
  logic [XLEN-1:0]        mask;
  logic                   uns;

  assign bit_off = {off, 3'b000};
  assign uns     = funct3[2];

  always_comb begin
    shifted   = word >> bit_off;
    load_data = '0;
    mask      = '0;
    case (funct3[1:0])
      SZ_B: begin
        load_data = {{(XLEN-8){~uns & shifted[7]}}, shifted[7:0]};
        mask      = {{(XLEN-8){1'b0}}, 8'hFF};
      end
      SZ_H: begin
        load_data = {{(XLEN-16){~uns & shifted[15]}}, shifted[15:0]};
        mask      = {{(XLEN-16){1'b0}}, 16'hFFFF};
      end
      SZ_W: begin
        load_data = {{(XLEN-32){~uns & shifted[31]}}, shifted[31:0]};
        mask      = {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF};
      end
      default: begin
        load_data = shifted;
        mask      = '1;
      end
    endcase
    // Byte-merge: only lanes [off, off+size) take new data.
    store_word = (word & ~(mask << bit_off)) | ((wdata << bit_off) & (mask << bit_off));
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage sequencer for RV64 loads/stores against a
// 64-bit doubleword-addressed memory.
//   req_*   : one request per valid/ready handshake (ready only in IDLE)
//   resp_*  : one-cycle completion pulse with load data or fault flag
//   mem_*   : read/write strobes, aligned address, full write word;
//             mem_read_data is combinational from the memory
// Sub-doubleword stores are done as read-modify-write. Misaligned or
// illegal requests complete with resp_fault and never touch memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN        = LSU_XLEN,
  parameter int OFFSET_BITS = LSU_OFFSET_BITS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_fault,
  output logic            mem_read,
  output logic            mem_write,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_write_data,
  input  logic [XLEN-1:0] mem_read_data
);

  lsu_state_e      state, state_nxt;
  lsu_req_t        req_q;
  logic [XLEN-1:0] old_q;
  logic            accept;
  logic            bad;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] store_word;

  assign req_ready = (state == S_IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  always_comb begin
    bad = is_misaligned(req_funct3[1:0], req_addr[OFFSET_BITS-1:0]);
    if (req_is_store) bad = bad | req_funct3[2];
    else              bad = bad | (req_funct3 == 3'b111);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      req_q <= '0;
      old_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) req_q <= '{is_store: req_is_store, funct3: req_funct3,
                             addr: req_addr, wdata: req_wdata};
      if (state == S_LOAD_RD || state == S_RMW_RD) old_q <= mem_read_data;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (bad)                         state_nxt = S_FAULT;
          else if (!req_is_store)          state_nxt = S_LOAD_RD;
          else if (req_funct3[1:0] == SZ_D) state_nxt = S_STORE_WR;
          else                             state_nxt = S_RMW_RD;
        end
      end
      S_LOAD_RD:  state_nxt = S_RESP;
      S_STORE_WR: state_nxt = S_RESP;
      S_RMW_RD:   state_nxt = S_RMW_WR;
      S_RMW_WR:   state_nxt = S_RESP;
      default:    state_nxt = S_IDLE;
    endcase
  end

  lsu_align #(.XLEN(XLEN), .OFFSET_BITS(OFFSET_BITS)) u_align (
    .word       (old_q),
    .off        (req_q.addr[OFFSET_BITS-1:0]),
    .funct3     (req_q.funct3),
    .wdata      (req_q.wdata),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // All memory-side outputs decode from registered state only.
  always_comb begin
    mem_read       = (state == S_LOAD_RD) || (state == S_RMW_RD);
    mem_write      = (state == S_STORE_WR) || (state == S_RMW_WR);
    mem_address    = '0;
    mem_write_data = '0;
    if (mem_read || mem_write)
      mem_address = {req_q.addr[XLEN-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    if (state == S_STORE_WR) mem_write_data = req_q.wdata;
    if (state == S_RMW_WR)   mem_write_data = store_word;
    resp_valid = (state == S_RESP) || (state == S_FAULT);
    resp_fault = (state == S_FAULT);
    resp_rdata = (state == S_RESP && !req_q.is_store) ? load_data : '0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [63:0] resp_rdata;
  logic        mem_read, mem_write;
  logic [63:0] mem_address, mem_write_data, mem_read_data;

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Data memory: 16 doublewords, decoded on address bits [6:3].
  logic [63:0] mem [0:15];
  assign mem_read_data = mem[mem_address[6:3]];
  always @(posedge clk) if (mem_write) mem[mem_address[6:3]] <= mem_write_data;

  // Reference model: flat byte array with plain byte arithmetic.
  logic [7:0] ref_b [0:127];

  typedef struct {
    logic [63:0] rdata;
    logic        fault;
    int          lat;
    int          acc;
    logic [63:0] maddr;
  } exp_t;
  exp_t q[$];

  int cyc = 0;
  int npass = 0, ntot = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic ref_fault(input logic st, input logic [2:0] f3, input logic [63:0] a);
    int n = 1 << f3[1:0];
    if (st && f3 > 3) return 1'b1;
    if (!st && f3 == 3'd7) return 1'b1;
    return (int'(a[6:0]) % n) != 0;
  endfunction

  function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] a);
    int n = 1 << f3[1:0];
    int base = int'(a[6:0]);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = v | (64'(ref_b[base + i]) << (8 * i));
    if (!f3[2] && n < 8 && v[8*n-1]) v = v | ({64{1'b1}} << (8 * n));
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
    int n = 1 << f3[1:0];
    int base = int'(a[6:0]);
    for (int i = 0; i < n; i++) ref_b[base + i] = wd[8*i +: 8];
  endtask

  // Issue one request; when track=1 the expected response is queued.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, input logic track);
    exp_t e;
    int t = 0;
    @(negedge clk);
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    if (!req_ready) begin
      chk("ready_timeout", {63'd0, req_ready}, 64'd1);
      return;
    end
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    e.fault = ref_fault(st, f3, a);
    e.maddr = {a[63:3], 3'b000};
    e.rdata = '0;
    if (e.fault)  e.lat = 1;
    else if (!st) begin e.lat = 2; e.rdata = ref_load(f3, a); end
    else          e.lat = (f3[1:0] == 2'b11) ? 2 : 3;
    if (track && st && !e.fault) ref_store(f3, a, wd);
    @(posedge clk); #1;
    e.acc = cyc;
    if (track) q.push_back(e);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 20) begin @(negedge clk); t++; end
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  // Monitor: pops expectations as the DUT presents responses.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (mem_read && mem_write) chk("rd_wr_both", 64'd1, 64'd0);
      if (q.size() != 0) begin
        chk("ready_busy", {63'd0, req_ready}, 64'd0);
        if (mem_read || mem_write) begin
          chk("strobe_on_fault", {63'd0, q[0].fault}, 64'd0);
          chk("mem_address", mem_address, q[0].maddr);
        end
      end
      if (resp_valid) begin
        if (q.size() == 0) chk("unexpected_resp", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_fault", {63'd0, resp_fault}, {63'd0, e.fault});
          chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
        end
      end
    end
  end

  initial begin
    logic [63:0] a, wd, w;
    logic [2:0]  f3;
    logic        st;
    int          t, n;
    reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};
    mem[1] = 64'd20; mem[2] = 64'h1E; mem[3] = 64'd40;
    for (int i = 0; i < 16; i++)
      for (int b = 0; b < 8; b++) ref_b[8*i + b] = mem[i][8*b +: 8];

    @(negedge clk);
    chk("rst_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_mem_strobes", {62'd0, mem_read, mem_write}, 64'd0);
    chk("rst_mem_address", mem_address, 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    @(negedge clk); reset = 1'b0;

    // Directed cases
    issue(1'b0, 3'b011, 64'h8, 64'd0, 1'b1);                 // LD 0x8 -> 20
    issue(1'b1, 3'b000, 64'h11, 64'hAB, 1'b1);               // SB
    drain();
    chk("sb_word", mem[2], 64'h0000_0000_0000_AB1E);
    issue(1'b0, 3'b000, 64'h11, 64'd0, 1'b1);                // LB
    issue(1'b0, 3'b100, 64'h11, 64'd0, 1'b1);                // LBU
    issue(1'b0, 3'b001, 64'h10, 64'd0, 1'b1);                // LH
    issue(1'b0, 3'b010, 64'h6, 64'd0, 1'b1);                 // misaligned LW
    issue(1'b0, 3'b111, 64'h8, 64'd0, 1'b1);                 // illegal load
    issue(1'b1, 3'b100, 64'h8, 64'd0, 1'b1);                 // illegal store
    drain();

    // Reset during RMW_WR of SH 0x1A: no write, no response
    issue(1'b1, 3'b001, 64'h1A, 64'hBEEF, 1'b0);
    t = 0;
    @(negedge clk);
    while (!mem_write && t < 10) begin @(negedge clk); t++; end
    chk("rmw_wr_reached", {63'd0, mem_write}, 64'd1);
    reset = 1'b1; #1;
    chk("rst_mid_mem_write", {63'd0, mem_write}, 64'd0);
    chk("rst_mid_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_mid_ready", {63'd0, req_ready}, 64'd0);
    @(negedge clk); reset = 1'b0; #1;
    chk("rst_mid_word", mem[3], 64'd40);
    chk("ready_after_rst", {63'd0, req_ready}, 64'd1);
    @(negedge clk);
    chk("no_resp_after_rst", {63'd0, resp_valid}, 64'd0);
    issue(1'b0, 3'b011, 64'h18, 64'd0, 1'b1);                // LD -> 40

    // Back-to-back SD then LW
    issue(1'b1, 3'b011, 64'h20, 64'h1122334455667788, 1'b1);
    issue(1'b0, 3'b010, 64'h24, 64'd0, 1'b1);
    drain();

    // Randomized traffic, upper address bits random, mostly aligned
    for (int k = 0; k < 300; k++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = {$urandom, $urandom};
      wd = {$urandom, $urandom};
      n  = 1 << f3[1:0];
      if ($urandom_range(0, 3) != 0) a = a & ~64'(n - 1);
      issue(st, f3, a, wd, 1'b1);
    end
    drain();

    for (int i = 0; i < 16; i++) begin
      for (int b = 0; b < 8; b++) w[8*b +: 8] = ref_b[8*i + b];
      chk("final_mem", mem[i], w);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
